// File: rtl/bcd_chain_pkg.sv
// Shared encodings for the cascaded BCD counter sequencer: state codes,
// command codes and BCD digit helpers.
package bcd_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_PAUSE = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_LOAD  = 2'd3
    } cmd_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic nibble_is_bcd(input logic [3:0] nib);
        return (nib <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter cell of the chain: clears, or increments 0..9 with
// wrap, and reports terminal count (q == 9) to the digits above it.
module bcd_digit
    import bcd_chain_pkg::*;
(
    input  logic       CP,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       tc
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next digit value: clear has priority over increment.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : (q_q + 4'd1);
        end else begin
            q_d = q_q;
        end
    end

    // Digit register.
    always_ff @(posedge CP) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign tc = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_chain_ctrl.sv
// Sequencer for a chain of BCD digits: prescaled stepping, command handshake
// and target compare. Define BCD_CHAIN_AUTO_RELOAD_EN to restart from zero
// on a target match instead of stopping in DONE.
module bcd_chain_ctrl
    import bcd_chain_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                CP,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd,
    input  logic [4*DIGITS-1:0] cmd_data,
    output logic                cmd_ready,
    output logic [4*DIGITS-1:0] Q,
    output logic                running,
    output logic                done,
    output logic                ovf,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [W-1:0]    target_q, target_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;

    logic [DIGITS-1:0] tc_s;
    logic [DIGITS-1:0] inc_s;
    logic [W-1:0]      q_s;
    logic [W-1:0]      next_q_s;
    logic              lower_nines_s;
    logic              load_ok_s;
    logic              pre_last_s;
    logic              step_s;
    logic              accept_s;
    logic              match_s;
    logic              clr_s;

    assign pre_last_s = (pre_q == PRE_LAST);
    assign step_s     = (state_q == ST_RUN) && tick_in && pre_last_s;
    // A pending step owns the cycle; any command waits one clock.
    assign cmd_ready  = (state_q != ST_RUN) || !(tick_in && pre_last_s);
    assign accept_s   = cmd_valid && cmd_ready;
    assign match_s    = step_s && (next_q_s == target_q);

    // Ripple enables and the post-step count used for target compare.
    always_comb begin
        inc_s         = '0;
        next_q_s      = q_s;
        lower_nines_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            lower_nines_s = 1'b1;
            for (int j = 0; j < i; j++) begin
                lower_nines_s = lower_nines_s & tc_s[j];
            end
            inc_s[i] = step_s && lower_nines_s;
            if (inc_s[i]) begin
                next_q_s[4*i +: 4] = tc_s[i] ? 4'd0 : (q_s[4*i +: 4] + 4'd1);
            end else begin
                next_q_s[4*i +: 4] = q_s[4*i +: 4];
            end
        end
    end

    // LOAD data is accepted only if every nibble is a decimal digit.
    always_comb begin
        load_ok_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            load_ok_s = load_ok_s & nibble_is_bcd(cmd_data[4*i +: 4]);
        end
    end

    // Next-state, prescaler, target and pulse flags.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        target_d = target_q;
        clr_s    = 1'b0;
        done_d   = match_s;
        ovf_d    = step_s && (&tc_s);
        err_d    = 1'b0;

        if (step_s) begin
            pre_d = '0;
        end else if ((state_q == ST_RUN) && tick_in) begin
            pre_d = pre_q + PW'(1);
        end else begin
            pre_d = pre_q;
        end

        if (match_s) begin
`ifdef BCD_CHAIN_AUTO_RELOAD_EN
            clr_s = 1'b1;
`else
            state_d = ST_DONE;
`endif
        end else begin
            state_d = state_q;
        end

        // Accept and step never coincide, so commands cannot mask a match.
        if (accept_s) begin
            case (cmd_e'(cmd))
                CMD_START: begin
                    case (state_q)
                        ST_IDLE: begin
                            state_d = ST_RUN;
                            pre_d   = '0;
                        end
                        ST_PAUSE: state_d = ST_RUN;
                        ST_DONE: begin
                            state_d = ST_RUN;
                            pre_d   = '0;
                            clr_s   = 1'b1;
                        end
                        default: state_d = state_q;
                    endcase
                end
                CMD_PAUSE: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = state_q;
                    end
                end
                CMD_CLEAR: begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                    clr_s   = 1'b1;
                end
                CMD_LOAD: begin
                    if (load_ok_s) begin
                        target_d = cmd_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            target_d = target_q;
        end

        running_d = (state_d == ST_RUN);
    end

    // Controller registers.
    always_ff @(posedge CP) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            target_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            target_q  <= target_d;
            running_q <= running_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .CP  (CP),
            .rst (rst),
            .clr (clr_s),
            .inc (inc_s[g]),
            .q   (q_s[4*g +: 4]),
            .tc  (tc_s[g])
        );
    end

    assign Q       = q_s;
    assign running = running_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Directed bench for bcd_chain_ctrl (DIGITS=2, PRESCALE=3) with a decimal
// reference model feeding a per-cycle scoreboard.
module tb_bcd_chain_ctrl;

    localparam int PS = 3;
    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_PAUSE = 2'd1;
    localparam logic [1:0] C_CLEAR = 2'd2;
    localparam logic [1:0] C_LOAD  = 2'd3;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       CP = 1'b0;
    logic       rst = 1'b0;
    logic       tick_in = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic [7:0] Q;
    logic       running, done, ovf, err;

    bcd_chain_ctrl #(.DIGITS(2), .PRESCALE(PS)) dut (
        .CP        (CP),
        .rst       (rst),
        .tick_in   (tick_in),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .Q         (Q),
        .running   (running),
        .done      (done),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 CP = ~CP;

    typedef struct packed {
        logic [7:0] q;
        logic       running;
        logic       done;
        logic       ovf;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt = 0, m_pre = 0, m_state = S_IDLE, m_tgt = 0;

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] tens, units;
        tens  = 4'(n / 10);
        units = 4'(n % 10);
        return {tens, units};
    endfunction

    function automatic bit bcd_ok(input logic [7:0] d);
        return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
    endfunction

    function automatic int from_bcd(input logic [7:0] d);
        return int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, advance model, compare after posedge.
    task automatic cyc(input logic t, input logic v, input logic [1:0] c,
                       input logic [7:0] d, input logic r, output bit acc);
        exp_t e;
        bit rdy, stp, nd, no, ne;
        @(negedge CP);
        tick_in = t; cmd_valid = v; cmd = c; cmd_data = d; rst = r;
        #1;
        acc = 1'b0;
        nd = 1'b0; no = 1'b0; ne = 1'b0;
        if (r) begin
            m_cnt = 0; m_pre = 0; m_state = S_IDLE; m_tgt = 0;
        end else begin
            rdy = (m_state != S_RUN) || !(t && m_pre == PS - 1);
            check("cmd_ready", {7'd0, cmd_ready}, {7'd0, rdy});
            stp = (m_state == S_RUN) && t && (m_pre == PS - 1);
            if (stp) begin
                m_pre = 0;
                if (m_cnt == 99) begin
                    m_cnt = 0;
                    no = 1'b1;
                end else begin
                    m_cnt++;
                end
                if (m_cnt == m_tgt) begin
                    nd = 1'b1;
`ifdef BCD_CHAIN_AUTO_RELOAD_EN
                    m_cnt = 0;
`else
                    m_state = S_DONE;
`endif
                end
            end else if (m_state == S_RUN && t) begin
                m_pre++;
            end
            acc = v && rdy;
            if (acc) begin
                case (c)
                    C_START: begin
                        if (m_state == S_IDLE) begin
                            m_state = S_RUN; m_pre = 0;
                        end else if (m_state == S_PAUSE) begin
                            m_state = S_RUN;
                        end else if (m_state == S_DONE) begin
                            m_state = S_RUN; m_cnt = 0; m_pre = 0;
                        end
                    end
                    C_PAUSE: if (m_state == S_RUN) m_state = S_PAUSE;
                    C_CLEAR: begin
                        m_cnt = 0; m_pre = 0; m_state = S_IDLE;
                    end
                    default: begin
                        if (bcd_ok(d)) m_tgt = from_bcd(d);
                        else ne = 1'b1;
                    end
                endcase
            end
        end
        e.q = to_bcd(m_cnt);
        e.running = (m_state == S_RUN);
        e.done = nd; e.ovf = no; e.err = ne;
        sb.push_back(e);
        @(posedge CP);
        #1;
        e = sb.pop_front();
        check("Q", Q, e.q);
        check("running", {7'd0, running}, {7'd0, e.running});
        check("done", {7'd0, done}, {7'd0, e.done});
        check("ovf", {7'd0, ovf}, {7'd0, e.ovf});
        check("err", {7'd0, err}, {7'd0, e.err});
    endtask

    task automatic idle_cmd(input logic [1:0] c, input logic [7:0] d);
        bit a;
        cyc(1'b0, 1'b1, c, d, 1'b0, a);
    endtask

    task automatic run(input int n, input logic t);
        bit a;
        for (int i = 0; i < n; i++) cyc(t, 1'b0, 2'd0, 8'h00, 1'b0, a);
    endtask

    // Keep the command valid with ticks running until it is taken.
    task automatic held_cmd(input string tag, input logic [1:0] c, input logic [7:0] d,
                            input int exp_stalls);
        bit a;
        int k;
        k = 0;
        a = 1'b0;
        while (!a && k < 6) begin
            cyc(1'b1, 1'b1, c, d, 1'b0, a);
            if (!a) k++;
        end
        check({tag, "_stalls"}, 8'(k), 8'(exp_stalls));
    endtask

    task automatic run_until_pre_last();
        int k;
        k = 0;
        while (m_pre != PS - 1 && k < 8) begin
            run(1, 1'b1);
            k++;
        end
        check("pre_reach", 8'(m_pre), 8'(PS - 1));
    endtask

    task automatic run_until_cnt(input int n, input int budget);
        int k;
        k = 0;
        while (!(m_cnt == n && m_pre == 0) && k < budget) begin
            run(1, 1'b1);
            k++;
        end
        check("cnt_reach", to_bcd(m_cnt), to_bcd(n));
    endtask

    initial begin
        bit a;
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, a);
        check("ready_after_reset", {7'd0, cmd_ready}, 8'd1);
        check("q_after_reset", Q, 8'h00);

        // Count to 25 with a tick every cycle: 75 ticks.
        idle_cmd(C_LOAD, 8'h25);
        idle_cmd(C_START, 8'h00);
        run(80, 1'b1);
`ifndef BCD_CHAIN_AUTO_RELOAD_EN
        check("hold_at_target", Q, 8'h25);
        check("stopped", {7'd0, running}, 8'd0);
`endif

        // Non-BCD load rejected, then restart from DONE reuses target 25.
        idle_cmd(C_LOAD, 8'h3A);
        idle_cmd(C_START, 8'h00);
        run(80, 1'b1);

        // Load held across a step cycle stalls exactly once.
        idle_cmd(C_CLEAR, 8'h00);
        idle_cmd(C_LOAD, 8'h00);
        idle_cmd(C_START, 8'h00);
        run_until_pre_last();
        held_cmd("load_stall", C_LOAD, 8'h50, 1);

        // Pause with prescaler at its last value, tick while paused, resume.
        run_until_pre_last();
        idle_cmd(C_PAUSE, 8'h00);
        run(5, 1'b1);
        idle_cmd(C_START, 8'h00);
        run(1, 1'b1);
        run(160, 1'b1);

        // Free-run past 60, load 50 below Q, wrap 99->00 then stop at 50.
        idle_cmd(C_LOAD, 8'h00);
        idle_cmd(C_START, 8'h00);
        run_until_cnt(60, 200);
        held_cmd("load_low", C_LOAD, 8'h50, 0);
        run(300, 1'b1);

        // Target zero matches on the overflow wrap.
        idle_cmd(C_LOAD, 8'h00);
        idle_cmd(C_START, 8'h00);
        run(310, 1'b1);

        // Reset in the middle of a run at 47.
        idle_cmd(C_CLEAR, 8'h00);
        idle_cmd(C_LOAD, 8'h80);
        idle_cmd(C_START, 8'h00);
        run_until_cnt(47, 200);
        cyc(1'b1, 1'b1, C_START, 8'h00, 1'b1, a);
        check("q_reset_mid", Q, 8'h00);
        run(3, 1'b1);
        idle_cmd(C_START, 8'h00);
        run(12, 1'b1);

`ifdef BCD_CHAIN_AUTO_RELOAD_EN
        idle_cmd(C_CLEAR, 8'h00);
        idle_cmd(C_LOAD, 8'h03);
        idle_cmd(C_START, 8'h00);
        run(20, 1'b1);
        check("auto_running", {7'd0, running}, 8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_chain_ctrl.md
Name: bcd_chain_ctrl

Overview:
- Sequencer for a chain of DIGITS cascaded decade (BCD) counter cells.
- Gates counting with a tick prescaler and accepts start/pause/clear/load-target commands over a valid/ready handshake.
- Stops and flags completion when the count equals a programmed target.
- Sits between the control/host logic and the display/compare logic of the timer path.

Parameters:
- DIGITS, 4: number of BCD digits in the chain (1..8); count width = 4*DIGITS.
- PRESCALE, 10: tick_in pulses per count increment (1..1023).

Ports:
- CP  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- tick_in  input  1  time-base enable pulse; sampled only in RUN.
- cmd_valid  input  1  command present.
- cmd  input  2  command code: 0 START, 1 PAUSE, 2 CLEAR, 3 LOAD.
- cmd_data  input  4*DIGITS  BCD target for LOAD; ignored otherwise.
- cmd_ready  output  1  command accepted on CP edge when cmd_valid && cmd_ready.
- Q  output  4*DIGITS  current BCD count; digit 0 = bits [3:0].
- running  output  1  high in RUN.
- done  output  1  one-cycle pulse on reaching target.
- ovf  output  1  one-cycle pulse on wrap from all-9s to all-0s.
- err  output  1  one-cycle pulse on a rejected LOAD.

Behaviour:
- Reset (rst=1 at CP edge): Q=0, target=0, prescaler=0, state=IDLE. running, done, ovf, err = 0; cmd_ready=1 in the cycle after reset.
- States: IDLE, RUN, PAUSE, DONE.
- step = (state==RUN) && tick_in && (prescaler==PRESCALE-1).
- Prescaler:
  - Increments on each tick_in in RUN; wraps to 0 on step.
  - Holds its value in PAUSE.
  - Cleared by CLEAR, by START from IDLE/DONE, and by reset.
- Increment on step (ripple rules):
  - Digit i increments when all digits below it equal 9; digit 0 increments on every step.
  - A digit at 9 that increments wraps to 0.
  - Non-BCD digit values are unreachable.
- Overflow: count all-9s plus step gives all-0s, and ovf pulses the next cycle. Counting continues unless target=0 matches (see target compare).
- Target compare:
  - target==0 means free-run, except that an overflow to 0 then also matches.
  - If the post-step value equals target (nonzero target), state becomes DONE on that same edge and done=1 for the following cycle only.
  - Q holds at target while in DONE.
- cmd_ready = 1 in IDLE, PAUSE and DONE. In RUN it is !(tick_in && prescaler==PRESCALE-1).
  - A step therefore always wins over a command; the command stalls one cycle.
- Command effects (on accept):
  - START: IDLE→RUN. PAUSE→RUN (Q and prescaler kept). DONE→RUN with Q=0, prescaler=0. In RUN it is a no-op.
  - PAUSE: RUN→PAUSE; no-op elsewhere.
  - CLEAR: Q=0, prescaler=0, state=IDLE from any state; target is kept.
  - LOAD: if every nibble of cmd_data is ≤9, target=cmd_data; otherwise target is unchanged and err=1 next cycle.
    - State is unchanged either way.
    - Loading a target ≤ the current Q in RUN does not trigger done until the count wraps around to it.
- Reset mid-RUN: reset dominates all commands and steps; no done/ovf pulse is emitted.

Optional Feature:
- Macro: BCD_CHAIN_AUTO_RELOAD_EN.
- Defined: on a target match, Q becomes 0 and state stays RUN on the same edge; done still pulses. DONE state is unreachable.
- Undefined: behaviour as above; the block stops in DONE.

Decomposition:
- Shared package bcd_chain_pkg:
  - state encoding constants (IDLE=0, RUN=1, PAUSE=2, DONE=3);
  - command codes (CMD_START, CMD_PAUSE, CMD_CLEAR, CMD_LOAD);
  - constant BCD_MAX=4'd9.
- Sub-module bcd_digit, one per digit via generate:
  - inputs: CP, rst, clr, inc;
  - outputs: 4-bit q, tc (q==9);
  - synchronous active-high reset.
- The controller builds each digit's inc from step AND the tc outputs of all lower digits.

Test Plan:
- DIGITS=2, PRESCALE=3; LOAD 8'h25, START, tick_in always 1 → Q advances every 3 CP cycles; reaches 8'h25 after 75 ticks; done=1 for one cycle; running=0; Q holds 8'h25.
- Q=8'h09, step → Q=8'h10. Q=8'h99 with target 8'h50, step → Q=8'h00, ovf=1 one cycle.
- RUN with prescaler=2, PAUSE, 5 tick_in, START → Q unchanged during pause; next tick_in produces a step.
- LOAD 8'h3A → err=1 one cycle, target unchanged. LOAD with cmd_valid held during a step cycle → cmd_ready=0 that cycle; accepted the next cycle.
- rst=1 asserted mid-RUN at Q=8'h47 → next cycle Q=0, IDLE, target=0; no done/ovf.
- With BCD_CHAIN_AUTO_RELOAD_EN, target 8'h03 → done pulses every 3 steps; Q sequence 1,2,0,1,2,0; running stays 1.
